// File: rtl/qam_demapper_serial_if.sv
// qam_demapper_serial_if: sample-side handshake and serial bit-side signals of
// the serial QAM demapper. The sample source / bit consumer uses the master
// modport, the demapper uses the slave modport.
interface qam_demapper_serial_if #(
    parameter int IN_W = 8
);
    logic                   en;
    logic                   cal;
    logic [1:0]             mode;
    logic signed [IN_W-1:0] i_in;
    logic signed [IN_W-1:0] q_in;
    logic                   in_valid;
    logic                   in_ready;
    logic                   bit_out;
    logic                   bit_valid;
    logic                   sym_start;
    logic                   cal_busy;
    logic                   low_conf;

    modport master (
        output en, cal, mode, i_in, q_in, in_valid,
        input  in_ready, bit_out, bit_valid, sym_start, cal_busy, low_conf
    );

    modport slave (
        input  en, cal, mode, i_in, q_in, in_valid,
        output in_ready, bit_out, bit_valid, sym_start, cal_busy, low_conf
    );
endinterface

// File: rtl/qam_demapper_serial.sv
// qam_demapper_serial: hard-decision QPSK / 16QAM / 64QAM demapper with DC
// offset calibration and an MSB-first serial bit output.
//
// Optional feature macro: QAM_LOWCONF_EN
//   defined   -> low_conf flags symbols whose corrected I or Q sample lies
//                within ERASE_MARGIN LSBs of a live decision threshold.
//   undefined -> low_conf is tied to 0 and no comparator logic is built.
module qam_demapper_serial #(
    parameter int IN_W     = 8,
    parameter int CAL_LOG2 = 4
`ifdef QAM_LOWCONF_EN
    ,
    parameter int ERASE_MARGIN = 8
`endif
) (
    input  logic                 sclk,
    input  logic                 rst,
    qam_demapper_serial_if.slave bus
);

    localparam int ACC_W = IN_W + CAL_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CAL   = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t                  r_state;
    logic signed [IN_W-1:0]  r_off_i;
    logic signed [IN_W-1:0]  r_off_q;
    logic signed [ACC_W-1:0] r_acc_i;
    logic signed [ACC_W-1:0] r_acc_q;
    logic [CAL_LOG2-1:0]     r_cal_cnt;
    logic [4:0]              r_shift;      // bits still to send after the current one
    logic [2:0]              r_cnt;        // bits remaining after the current one
    logic                    r_bit_out;
    logic                    r_bit_valid;
    logic                    r_sym_start;
    logic                    r_cal_busy;

    logic                    w_ready_raw;
    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_load;
    logic [1:0]              w_nb;         // bits per axis: 1, 2 or 3
    logic signed [IN_W-1:0]  w_c_i;
    logic signed [IN_W-1:0]  w_c_q;
    logic [2:0]              w_idx_i;
    logic [2:0]              w_idx_q;
    logic [2:0]              w_gray_i;
    logic [2:0]              w_gray_q;
    logic [5:0]              w_word;       // symbol word, left-aligned
    logic [2:0]              w_bits_m1;    // symbol length minus one
    logic signed [ACC_W-1:0] w_sum_i;
    logic signed [ACC_W-1:0] w_sum_q;

    // Offset removal, saturated back into the IN_W signed range.
    function automatic logic signed [IN_W-1:0] sat_sub(
        input logic signed [IN_W-1:0] s,
        input logic signed [IN_W-1:0] o
    );
        logic signed [IN_W:0] d;
        d = {s[IN_W-1], s} - {o[IN_W-1], o};
        if (d[IN_W] != d[IN_W-1]) begin
            return d[IN_W] ? {1'b1, {(IN_W-1){1'b0}}} : {1'b0, {(IN_W-1){1'b1}}};
        end
        return d[IN_W-1:0];
    endfunction

    // Level index = number of thresholds strictly below c. With u = c + 2^(IN_W-1)
    // the thresholds sit at u = k*step, so c > t_k <=> u-1 >= k*step and the
    // index is simply the top nb bits of u-1 (u = 0 is below every threshold).
    function automatic logic [2:0] level_idx(
        input logic signed [IN_W-1:0] c,
        input logic [1:0]             nb
    );
        logic [IN_W-1:0] u;
        logic [2:0]      top;
        u   = {~c[IN_W-1], c[IN_W-2:0]};
        top = 3'((u - IN_W'(1)) >> (IN_W - 3));
        if (u == '0) begin
            return 3'd0;
        end
        case (nb)
            2'd1:    return {2'b00, top[2]};
            2'd3:    return top;
            default: return {1'b0, top[2:1]};
        endcase
    endfunction

    function automatic logic [2:0] gray3(input logic [2:0] x);
        return x ^ (x >> 1);
    endfunction

    // Bits per axis from the requested constellation; reserved code acts as 16QAM.
    always_comb begin
        case (bus.mode)
            2'd0:    w_nb = 2'd1;
            2'd2:    w_nb = 2'd3;
            default: w_nb = 2'd2;
        endcase
    end

    assign w_c_i   = sat_sub(bus.i_in, r_off_i);
    assign w_c_q   = sat_sub(bus.q_in, r_off_q);
    assign w_idx_i = level_idx(w_c_i, w_nb);
    assign w_idx_q = level_idx(w_c_q, w_nb);

    // Gray-map both axes (Q uses the mirrored index L-1-idx) and left-align the word.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the case can leave it unassigned and infer a latch.
        w_gray_i  = gray3(w_idx_i);
        w_gray_q  = 3'd0;
        w_word    = 6'd0;
        w_bits_m1 = 3'd3;
        case (w_nb)
            2'd1: begin
                w_gray_q  = gray3({2'b00, ~w_idx_q[0]});
                w_word    = {w_gray_i[0], w_gray_q[0], 4'b0000};
                w_bits_m1 = 3'd1;
            end
            2'd3: begin
                w_gray_q  = gray3(~w_idx_q);
                w_word    = {w_gray_i, w_gray_q};
                w_bits_m1 = 3'd5;
            end
            default: begin
                w_gray_q  = gray3({1'b0, ~w_idx_q[1:0]});
                w_word    = {w_gray_i[1:0], w_gray_q[1:0], 2'b00};
                w_bits_m1 = 3'd3;
            end
        endcase
    end

    // Ready: calibration takes priority over data; in SHIFT only on the last bit.
    always_comb begin
        w_ready_raw = 1'b0;
        case (r_state)
            ST_IDLE:  w_ready_raw = bus.en & ~bus.cal;
            ST_CAL:   w_ready_raw = bus.en;
            ST_SHIFT: w_ready_raw = (r_cnt == 3'd0) & bus.en & ~bus.cal;
            default:  w_ready_raw = 1'b0;
        endcase
    end

    // Ready is combinational, so it is forced low while reset is held.
    assign w_in_ready = w_ready_raw & ~rst;
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_load     = w_accept & (r_state != ST_CAL);

    assign w_sum_i = r_acc_i + {{CAL_LOG2{bus.i_in[IN_W-1]}}, bus.i_in};
    assign w_sum_q = r_acc_q + {{CAL_LOG2{bus.q_in[IN_W-1]}}, bus.q_in};

`ifdef QAM_LOWCONF_EN
    logic w_low_conf;
    logic r_low_conf;

    // True when c is within ERASE_MARGIN of any threshold of the chosen
    // constellation. All threshold sets are subsets of the 64QAM grid.
    function automatic logic near_threshold(
        input logic signed [IN_W-1:0] c,
        input logic [1:0]             nb
    );
        logic hit;
        int   t;
        int   d;
        hit = 1'b0;
        for (int j = 1; j < 8; j++) begin
            if (nb == 2'd3 || (nb == 2'd2 && (j % 2) == 0) || j == 4) begin
                t = (j - 4) * (1 << (IN_W - 3));
                d = int'(c) - t;
                if (d < ERASE_MARGIN && d > -ERASE_MARGIN) begin
                    hit = 1'b1;
                end
            end
        end
        return hit;
    endfunction

    assign w_low_conf = near_threshold(w_c_i, w_nb) | near_threshold(w_c_q, w_nb);

    // Confidence flag captured at acceptance; it appears with sym_start and
    // holds until the next symbol is loaded.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_low_conf <= 1'b0;
        end else if (w_load) begin
            r_low_conf <= w_low_conf;
        end
    end

    assign bus.low_conf = r_low_conf;
`else
    assign bus.low_conf = 1'b0;
`endif

    // Control FSM: calibration accumulate, symbol load and serial shift-out.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // register samples the pre-edge values regardless of statement order.
            r_state     <= ST_IDLE;
            r_off_i     <= '0;
            r_off_q     <= '0;
            r_acc_i     <= '0;
            r_acc_q     <= '0;
            r_cal_cnt   <= '0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_bit_out   <= 1'b0;
            r_bit_valid <= 1'b0;
            r_sym_start <= 1'b0;
            r_cal_busy  <= 1'b0;
        end else if (w_load) begin
            // New symbol from IDLE or on the last bit of the previous one.
            r_state     <= ST_SHIFT;
            r_bit_out   <= w_word[5];
            r_shift     <= w_word[4:0];
            r_cnt       <= w_bits_m1;
            r_bit_valid <= 1'b1;
            r_sym_start <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_bit_out   <= 1'b0;
                    r_bit_valid <= 1'b0;
                    r_sym_start <= 1'b0;
                    if (bus.cal && bus.en) begin
                        r_state    <= ST_CAL;
                        r_cal_busy <= 1'b1;
                    end
                end
                ST_CAL: begin
                    if (w_accept) begin
                        if (r_cal_cnt == '1) begin
                            // Arithmetic shift by CAL_LOG2 is just the upper IN_W bits.
                            r_off_i    <= w_sum_i[ACC_W-1:CAL_LOG2];
                            r_off_q    <= w_sum_q[ACC_W-1:CAL_LOG2];
                            r_acc_i    <= '0;
                            r_acc_q    <= '0;
                            r_cal_cnt  <= '0;
                            r_cal_busy <= 1'b0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_acc_i   <= w_sum_i;
                            r_acc_q   <= w_sum_q;
                            r_cal_cnt <= r_cal_cnt + CAL_LOG2'(1);
                        end
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt != 3'd0) begin
                        r_bit_out   <= r_shift[4];
                        r_shift     <= {r_shift[3:0], 1'b0};
                        r_cnt       <= r_cnt - 3'd1;
                        r_sym_start <= 1'b0;
                    end else begin
                        r_state     <= ST_IDLE;
                        r_bit_out   <= 1'b0;
                        r_bit_valid <= 1'b0;
                        r_sym_start <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.bit_out   = r_bit_out;
    assign bus.bit_valid = r_bit_valid;
    assign bus.sym_start = r_sym_start;
    assign bus.cal_busy  = r_cal_busy;

endmodule
